// File: rtl/multi_warp_wait_buffer_if.sv
// rtl/multi_warp_wait_buffer_if.sv - fetch/decode/writeback/dispatch bundle of the multi-warp wait buffer
interface multi_warp_wait_buffer_if #(
    parameter int NumWarps        = 8,
    parameter int NumTags         = 8,
    parameter int PcWidth         = 32,
    parameter int WarpWidth       = 32,
    parameter int RegIdxWidth     = 6,
    parameter int OperandsPerInst = 2
);
    localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;
    localparam int TagWidth = $clog2(NumTags);

    logic                                   fe_handshake_i;
    logic [WidWidth-1:0]                    fe_warp_id_i;
    logic [NumWarps-1:0]                    ib_space_available_o;
    logic [NumWarps-1:0]                    wb_ready_o;
    logic                                   dec_valid_i;
    logic [WidWidth-1:0]                    dec_warp_id_i;
    logic [PcWidth-1:0]                     dec_pc_i;
    logic [WarpWidth-1:0]                   dec_act_mask_i;
    logic [TagWidth-1:0]                    dec_tag_i;
    logic [RegIdxWidth-1:0]                 dec_dst_reg_i;
    logic [OperandsPerInst-1:0]             dec_operands_ready_i;
    logic [OperandsPerInst*TagWidth-1:0]    dec_operand_tags_i;
    logic [OperandsPerInst*RegIdxWidth-1:0] dec_operands_i;
    logic                                   eu_valid_i;
    logic [TagWidth-1:0]                    eu_tag_i;
    logic                                   opc_ready_i;
    logic                                   disp_valid_o;
    logic [WidWidth-1:0]                    disp_warp_id_o;
    logic [PcWidth-1:0]                     disp_pc_o;
    logic [WarpWidth-1:0]                   disp_act_mask_o;
    logic [TagWidth-1:0]                    disp_tag_o;
    logic [RegIdxWidth-1:0]                 disp_dst_reg_o;
    logic [OperandsPerInst*RegIdxWidth-1:0] disp_operands_o;

    modport master (
        output fe_handshake_i, fe_warp_id_i, dec_valid_i, dec_warp_id_i, dec_pc_i,
               dec_act_mask_i, dec_tag_i, dec_dst_reg_i, dec_operands_ready_i,
               dec_operand_tags_i, dec_operands_i, eu_valid_i, eu_tag_i, opc_ready_i,
        input  ib_space_available_o, wb_ready_o, disp_valid_o, disp_warp_id_o, disp_pc_o,
               disp_act_mask_o, disp_tag_o, disp_dst_reg_o, disp_operands_o
    );

    modport slave (
        input  fe_handshake_i, fe_warp_id_i, dec_valid_i, dec_warp_id_i, dec_pc_i,
               dec_act_mask_i, dec_tag_i, dec_dst_reg_i, dec_operands_ready_i,
               dec_operand_tags_i, dec_operands_i, eu_valid_i, eu_tag_i, opc_ready_i,
        output ib_space_available_o, wb_ready_o, disp_valid_o, disp_warp_id_o, disp_pc_o,
               disp_act_mask_o, disp_tag_o, disp_dst_reg_o, disp_operands_o
    );
endinterface

// File: rtl/multi_warp_wait_buffer.sv
// rtl/multi_warp_wait_buffer.sv - per-warp wait buffer with tag wakeup and round-robin dispatch (option macro: WAIT_BUFFER_OLDEST_FIRST_EN)
module multi_warp_wait_buffer #(
    parameter int NumWarps              = 8,
    parameter int NumTags               = 8,
    parameter int PcWidth               = 32,
    parameter int WarpWidth             = 32,
    parameter int WaitBufferSizePerWarp = 4,
    parameter int RegIdxWidth           = 6,
    parameter int OperandsPerInst       = 2
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    multi_warp_wait_buffer_if.slave bus
);
    localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;
    localparam int TagWidth = $clog2(NumTags);
    localparam int Size     = WaitBufferSizePerWarp;
    localparam int EntWidth = (Size > 1) ? $clog2(Size) : 1;
    localparam int CntWidth = $clog2(Size + 1);
    localparam int Ops      = OperandsPerInst;

    typedef struct packed {
        logic [PcWidth-1:0]         pc;
        logic [WarpWidth-1:0]       act_mask;
        logic [TagWidth-1:0]        tag;
        logic [RegIdxWidth-1:0]     dst_reg;
        logic [Ops*RegIdxWidth-1:0] operands;
    } payload_t;

    logic [Size-1:0]         valid_q   [NumWarps];
    logic [Size-1:0]         valid_d   [NumWarps];
    payload_t                payload_q [NumWarps][Size];
    payload_t                payload_d [NumWarps][Size];
    logic [Ops-1:0]          op_rdy_q  [NumWarps][Size];
    logic [Ops-1:0]          op_rdy_d  [NumWarps][Size];
    logic [Ops*TagWidth-1:0] op_tag_q  [NumWarps][Size];
    logic [Ops*TagWidth-1:0] op_tag_d  [NumWarps][Size];
    logic [CntWidth-1:0]     credit_q  [NumWarps];
    logic [CntWidth-1:0]     credit_d  [NumWarps];
    logic [WidWidth-1:0]     rr_q, rr_d;
    logic                    hold_q, hold_d;
    logic [WidWidth-1:0]     hold_w_q, hold_w_d;
    logic [EntWidth-1:0]     hold_e_q, hold_e_d;
`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
    // age_q[w][i][j] set means entry i of warp w was inserted before entry j.
    logic [Size-1:0]         age_q     [NumWarps][Size];
    logic [Size-1:0]         age_d     [NumWarps][Size];
`endif

    logic [Size-1:0]     ready [NumWarps];
    logic [NumWarps-1:0] warp_has_ready;
    logic [EntWidth-1:0] warp_pick [NumWarps];

    // Per-warp candidate: a valid entry with every operand present, lowest index or oldest.
    always_comb begin
`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
        logic older_ready;
        older_ready = 1'b0;
`endif
        for (int w = 0; w < NumWarps; w++) begin
            warp_has_ready[w] = 1'b0;
            warp_pick[w]      = '0;
            for (int e = 0; e < Size; e++) begin
                ready[w][e] = valid_q[w][e] && (&op_rdy_q[w][e]);
            end
`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
            for (int e = 0; e < Size; e++) begin
                older_ready = 1'b0;
                for (int j = 0; j < Size; j++) begin
                    if (ready[w][j] && age_q[w][j][e]) older_ready = 1'b1;
                end
                if (ready[w][e] && !older_ready && !warp_has_ready[w]) begin
                    warp_has_ready[w] = 1'b1;
                    warp_pick[w]      = EntWidth'(e);
                end
            end
`else
            for (int e = Size - 1; e >= 0; e--) begin
                if (ready[w][e]) begin
                    warp_has_ready[w] = 1'b1;
                    warp_pick[w]      = EntWidth'(e);
                end
            end
`endif
        end
    end

    logic                sel_found;
    logic [WidWidth-1:0] sel_w;
    logic [EntWidth-1:0] sel_e;

    // Round-robin scan across warps starting at rr_q.
    always_comb begin
        logic [WidWidth-1:0] cand;
        cand      = rr_q;
        sel_found = 1'b0;
        sel_w     = '0;
        sel_e     = '0;
        for (int k = 0; k < NumWarps; k++) begin
            if (!sel_found && warp_has_ready[cand]) begin
                sel_found = 1'b1;
                sel_w     = cand;
                sel_e     = warp_pick[cand];
            end
            cand = (cand == WidWidth'(NumWarps - 1)) ? '0 : cand + WidWidth'(1);
        end
    end

    // A stalled offer stays locked so late wakeups or inserts cannot reorder it.
    logic                disp_valid;
    logic [WidWidth-1:0] disp_w;
    logic [EntWidth-1:0] disp_e;
    logic                disp_hs;
    payload_t            disp_payload;

    assign disp_valid   = hold_q | sel_found;
    assign disp_w       = hold_q ? hold_w_q : sel_w;
    assign disp_e       = hold_q ? hold_e_q : sel_e;
    assign disp_hs      = disp_valid & bus.opc_ready_i;
    assign disp_payload = disp_valid ? payload_q[disp_w][disp_e] : '0;

    logic           ins_found;
    logic [EntWidth-1:0] ins_e;
    logic [Ops-1:0] ins_rdy;

    // Lowest free slot of the decoding warp; incoming operands also see this cycle's writeback.
    always_comb begin
        ins_found = 1'b0;
        ins_e     = '0;
        for (int e = Size - 1; e >= 0; e--) begin
            if (!valid_q[bus.dec_warp_id_i][e]) begin
                ins_found = 1'b1;
                ins_e     = EntWidth'(e);
            end
        end
        ins_rdy = bus.dec_operands_ready_i;
        for (int o = 0; o < Ops; o++) begin
            if (bus.eu_valid_i && bus.dec_operand_tags_i[o*TagWidth +: TagWidth] == bus.eu_tag_i) begin
                ins_rdy[o] = 1'b1;
            end
        end
    end

    logic [NumWarps-1:0] take, give, credit_zero, credit_full;

    // Credit bookkeeping per warp plus the status outputs derived from registered state.
    always_comb begin
        for (int w = 0; w < NumWarps; w++) begin
            take[w]        = bus.fe_handshake_i && (bus.fe_warp_id_i == WidWidth'(w));
            give[w]        = disp_hs && (disp_w == WidWidth'(w));
            credit_zero[w] = (credit_q[w] == '0);
            credit_full[w] = (credit_q[w] == CntWidth'(Size));
            credit_d[w]    = credit_q[w];
            if (take[w] && !give[w]) credit_d[w] = credit_q[w] - CntWidth'(1);
            if (give[w] && !take[w]) credit_d[w] = credit_q[w] + CntWidth'(1);
        end
    end

    // Entry state next value: wakeup, dispatch retire, insert, arbitration pointer and lock.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        op_rdy_d  = op_rdy_q;
        op_tag_d  = op_tag_q;
        rr_d      = rr_q;
        hold_d    = 1'b0;
        hold_w_d  = hold_w_q;
        hold_e_d  = hold_e_q;
`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
        age_d     = age_q;
`endif
        if (bus.eu_valid_i) begin
            for (int w = 0; w < NumWarps; w++) begin
                for (int e = 0; e < Size; e++) begin
                    for (int o = 0; o < Ops; o++) begin
                        if (valid_q[w][e] && !op_rdy_q[w][e][o] &&
                            op_tag_q[w][e][o*TagWidth +: TagWidth] == bus.eu_tag_i) begin
                            op_rdy_d[w][e][o] = 1'b1;
                        end
                    end
                end
            end
        end
        if (bus.dec_valid_i && ins_found) begin
            valid_d[bus.dec_warp_id_i][ins_e]          = 1'b1;
            payload_d[bus.dec_warp_id_i][ins_e].pc       = bus.dec_pc_i;
            payload_d[bus.dec_warp_id_i][ins_e].act_mask = bus.dec_act_mask_i;
            payload_d[bus.dec_warp_id_i][ins_e].tag      = bus.dec_tag_i;
            payload_d[bus.dec_warp_id_i][ins_e].dst_reg  = bus.dec_dst_reg_i;
            payload_d[bus.dec_warp_id_i][ins_e].operands = bus.dec_operands_i;
            op_rdy_d[bus.dec_warp_id_i][ins_e]         = ins_rdy;
            op_tag_d[bus.dec_warp_id_i][ins_e]         = bus.dec_operand_tags_i;
`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
            age_d[bus.dec_warp_id_i][ins_e] = '0;
            for (int i = 0; i < Size; i++) begin
                age_d[bus.dec_warp_id_i][i][ins_e] = valid_q[bus.dec_warp_id_i][i];
            end
`endif
        end
        if (disp_hs) begin
            valid_d[disp_w][disp_e] = 1'b0;
            rr_d = (disp_w == WidWidth'(NumWarps - 1)) ? '0 : disp_w + WidWidth'(1);
`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
            age_d[disp_w][disp_e] = '0;
            for (int i = 0; i < Size; i++) begin
                age_d[disp_w][i][disp_e] = 1'b0;
            end
`endif
        end else if (disp_valid) begin
            hold_d   = 1'b1;
            hold_w_d = disp_w;
            hold_e_d = disp_e;
        end
    end

    // State registers; reset drops every entry and refills all credits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NumWarps; w++) begin
                valid_q[w]  <= '0;
                credit_q[w] <= CntWidth'(Size);
                for (int e = 0; e < Size; e++) begin
                    payload_q[w][e] <= '0;
                    op_rdy_q[w][e]  <= '0;
                    op_tag_q[w][e]  <= '0;
`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
                    age_q[w][e]     <= '0;
`endif
                end
            end
            rr_q     <= '0;
            hold_q   <= 1'b0;
            hold_w_q <= '0;
            hold_e_q <= '0;
        end else begin
            valid_q   <= valid_d;
            credit_q  <= credit_d;
            payload_q <= payload_d;
            op_rdy_q  <= op_rdy_d;
            op_tag_q  <= op_tag_d;
`ifdef WAIT_BUFFER_OLDEST_FIRST_EN
            age_q     <= age_d;
`endif
            rr_q      <= rr_d;
            hold_q    <= hold_d;
            hold_w_q  <= hold_w_d;
            hold_e_q  <= hold_e_d;
        end
    end

    always_comb begin
        for (int w = 0; w < NumWarps; w++) begin
            bus.ib_space_available_o[w] = !credit_zero[w];
            bus.wb_ready_o[w]           = !(&valid_q[w]);
        end
    end

    assign bus.disp_valid_o    = disp_valid;
    assign bus.disp_warp_id_o  = disp_valid ? disp_w : '0;
    assign bus.disp_pc_o       = disp_payload.pc;
    assign bus.disp_act_mask_o = disp_payload.act_mask;
    assign bus.disp_tag_o      = disp_payload.tag;
    assign bus.disp_dst_reg_o  = disp_payload.dst_reg;
    assign bus.disp_operands_o = disp_payload.operands;

    credit_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (take & ~give & credit_zero) == '0);
    credit_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (give & ~take & credit_full) == '0);
    insert_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.dec_valid_i && !ins_found));
endmodule
